// File: rtl/clk_pattern_pkg.sv
// Shared types and limits for the programmable clock-pattern controller.
package clk_pattern_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PREP = 2'd1,
        HIGH = 2'd2,
        LOW  = 2'd3
    } state_t;

    localparam int DUTY_MAX = 100;
    localparam int JIT_MAX  = 50;
    localparam int P_MIN    = 2;

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR, x^16+x^14+x^13+x^11+1, stepped once per adv pulse.
module lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        adv,
    output logic [15:0] q
);
    // An all-zero state would lock the register, so substitute 1.
    localparam logic [15:0] SEED_NZ = (SEED == 16'h0000) ? 16'h0001 : SEED;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            q <= SEED_NZ;
        else if (adv)
            q <= {1'b0, q[15:1]} ^ (q[0] ? 16'hB400 : 16'h0000);
    end

endmodule

// File: rtl/clk_pattern_ctrl.sv
// Clock-pattern controller: jittered period, programmable duty, config via
// a one-deep shadow register that is applied only on period boundaries.
module clk_pattern_ctrl
    import clk_pattern_pkg::*;
#(
    parameter int          CNT_W     = 16,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic [6:0]       cfg_duty,
    input  logic [5:0]       cfg_jitter,
    output logic             cfg_err,
    output logic             out_clk,
    output logic             out_rise,
    output logic [CNT_W:0]   cur_period,
    output logic             busy
);
    localparam int PW = CNT_W + 1;

    state_t state, state_nxt;

    logic             shd_full;
    logic [CNT_W-1:0] shd_period, act_period, sel_period, cl_period;
    logic [6:0]       shd_duty, act_duty, sel_duty, cl_duty;
    logic [5:0]       shd_jit, act_jit, sel_jit, cl_jit;
    logic             xfer, clamp_any;

    logic [15:0]      lfsr_q;
    logic             s1_go, s2_vld, period_start;
    logic [CNT_W+5:0] jit_prod;
    logic [CNT_W-1:0] j_val, j_q;
    logic [PW-1:0]    span, r_val, r_q;
    logic [CNT_W+16:0] r_prod;
    logic [CNT_W+1:0] p_sum;
    logic [PW-1:0]    p_calc, h_raw, h_calc, l_calc;
    logic [PW+6:0]    h_prod;
    logic [PW-1:0]    nxt_p, nxt_h, nxt_l, st_p, st_h, st_l;
    logic [PW-1:0]    cur_h, cur_l, cnt;

    assign cfg_ready = !shd_full;
    assign busy      = (state != IDLE);
    assign xfer      = cfg_valid && !shd_full;

    assign cl_period = (cfg_period < CNT_W'(P_MIN))  ? CNT_W'(P_MIN)  : cfg_period;
    assign cl_duty   = (cfg_duty   > 7'(DUTY_MAX))   ? 7'(DUTY_MAX)   : cfg_duty;
    assign cl_jit    = (cfg_jitter > 6'(JIT_MAX))    ? 6'(JIT_MAX)    : cfg_jitter;
    assign clamp_any = (cfg_period < CNT_W'(P_MIN)) || (cfg_duty > 7'(DUTY_MAX)) ||
                       (cfg_jitter > 6'(JIT_MAX));

    // S1 sees a pending shadow directly so it takes effect in this calculation.
    assign sel_period = shd_full ? shd_period : act_period;
    assign sel_duty   = shd_full ? shd_duty   : act_duty;
    assign sel_jit    = shd_full ? shd_jit    : act_jit;

    assign s1_go = ((state == PREP) && !s2_vld) || ((state == HIGH) && (cnt == '0));

    lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .adv   (s1_go),
        .q     (lfsr_q)
    );

    // Stage 1: jitter span and random offset r in 0..2J.
    assign jit_prod = (CNT_W+6)'(sel_period) * (CNT_W+6)'(sel_jit);
    assign j_val    = CNT_W'(jit_prod / (CNT_W+6)'(100));
    assign span     = {j_val, 1'b1};
    assign r_prod   = (CNT_W+17)'(lfsr_q) * (CNT_W+17)'(span);
    assign r_val    = PW'(r_prod >> 16);

    // Stage 2: period length and high/low split.
    assign p_sum  = (CNT_W+2)'(act_period) + (CNT_W+2)'(r_q) - (CNT_W+2)'(j_q);
    assign p_calc = (p_sum < (CNT_W+2)'(P_MIN)) ? PW'(P_MIN) : PW'(p_sum);
    assign h_prod = (PW+7)'(p_calc) * (PW+7)'(act_duty);
    assign h_raw  = PW'(h_prod / (PW+7)'(100));

    always_comb begin
        h_calc = h_raw;
        if (h_raw == '0)
            h_calc = PW'(1);
        else if (h_raw >= p_calc)
            h_calc = p_calc - PW'(1);
    end

    assign l_calc = p_calc - h_calc;

    // A 2-cycle period ends in the same cycle S2 completes, so forward it.
    assign st_p = s2_vld ? p_calc : nxt_p;
    assign st_h = s2_vld ? h_calc : nxt_h;
    assign st_l = s2_vld ? l_calc : nxt_l;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shd_full   <= 1'b0;
            shd_period <= '0;
            shd_duty   <= '0;
            shd_jit    <= '0;
            act_period <= CNT_W'(P_MIN);
            act_duty   <= 7'd50;
            act_jit    <= '0;
            cfg_err    <= 1'b0;
        end else begin
            cfg_err <= xfer && clamp_any;
            if (s1_go) begin
                act_period <= sel_period;
                act_duty   <= sel_duty;
                act_jit    <= sel_jit;
                shd_full   <= 1'b0;
            end
            if (xfer) begin
                shd_period <= cl_period;
                shd_duty   <= cl_duty;
                shd_jit    <= cl_jit;
                shd_full   <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            j_q    <= '0;
            r_q    <= '0;
            s2_vld <= 1'b0;
            nxt_p  <= PW'(P_MIN);
            nxt_h  <= PW'(1);
            nxt_l  <= PW'(1);
        end else begin
            s2_vld <= s1_go;
            if (s1_go) begin
                j_q <= j_val;
                r_q <= r_val;
            end
            if (s2_vld) begin
                nxt_p <= p_calc;
                nxt_h <= h_calc;
                nxt_l <= l_calc;
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        period_start = 1'b0;
        case (state)
            IDLE: if (enable) state_nxt = PREP;
            PREP: if (s2_vld) begin
                state_nxt    = HIGH;
                period_start = 1'b1;
            end
            HIGH: if (cnt == cur_h - PW'(1)) state_nxt = LOW;
            LOW: if (cnt == cur_l - PW'(1)) begin
                if (enable) begin
                    state_nxt    = HIGH;
                    period_start = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            cur_h      <= PW'(1);
            cur_l      <= PW'(1);
            cur_period <= '0;
            out_clk    <= 1'b0;
            out_rise   <= 1'b0;
        end else begin
            state    <= state_nxt;
            out_clk  <= (state_nxt == HIGH);
            out_rise <= period_start;
            if ((state_nxt != state) || (state == IDLE))
                cnt <= '0;
            else
                cnt <= cnt + PW'(1);
            if (period_start) begin
                cur_period <= st_p;
                cur_h      <= st_h;
                cur_l      <= st_l;
            end
        end
    end

endmodule

// File: tb/tb_clk_pattern_ctrl.sv
// Bench for clk_pattern_ctrl: period-level reference model checked every cycle.
module tb_clk_pattern_ctrl;
    logic        clk = 1'b0, rst_n = 1'b0, enable = 1'b0, cfg_valid = 1'b0;
    logic [15:0] cfg_period = '0;
    logic [6:0]  cfg_duty = '0;
    logic [5:0]  cfg_jitter = '0;
    logic        cfg_ready, cfg_err, out_clk, out_rise, busy;
    logic [16:0] cur_period;

    always #5 clk = ~clk;

    clk_pattern_ctrl dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready), .cfg_period(cfg_period), .cfg_duty(cfg_duty),
        .cfg_jitter(cfg_jitter), .cfg_err(cfg_err), .out_clk(out_clk),
        .out_rise(out_rise), .cur_period(cur_period), .busy(busy)
    );

    int n_vec = 0, n_err = 0;

    localparam int MI = 0, MP1 = 1, MP2 = 2, MR = 3;
    int     m_mode;
    longint m_pos, m_P, m_H, n_P, n_H, m_lfsr;
    longint a_per, a_duty, a_jit, s_per, s_duty, s_jit;
    bit     m_full, m_xfer;
    bit     e_clk, e_rise, e_ready, e_err, e_busy;
    longint e_cur;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_vec++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = MI; m_pos = 0; m_P = 0; m_H = 0; n_P = 2; n_H = 1;
        m_lfsr = 'hACE1;
        a_per = 2; a_duty = 50; a_jit = 0; s_per = 0; s_duty = 0; s_jit = 0;
        m_full = 0; m_xfer = 0;
        e_clk = 0; e_rise = 0; e_ready = 1; e_err = 0; e_busy = 0; e_cur = 0;
    endtask

    // Spec arithmetic for one period, evaluated in a single step.
    task automatic calc(input longint per, input longint duty, input longint jit,
                        input longint lf, output longint p, output longint h);
        longint j, r;
        j = per * jit / 100;
        r = (lf * (2 * j + 1)) >> 16;
        p = per + r - j;
        if (p < 2) p = 2;
        h = p * duty / 100;
        if (h < 1) h = 1;
        if (h > p - 1) h = p - 1;
    endtask

    task automatic start_period();
        m_mode = MR; m_pos = 0; m_P = n_P; m_H = n_H;
        e_rise = 1; e_cur = n_P;
    endtask

    task automatic model_step();
        bit s1;
        m_xfer = cfg_valid && !m_full;
        s1 = (m_mode == MP1) || (m_mode == MR && m_pos == 0);
        e_err = 0; e_rise = 0;
        if (s1) begin
            if (m_full) begin
                a_per = s_per; a_duty = s_duty; a_jit = s_jit; m_full = 0;
            end
            calc(a_per, a_duty, a_jit, m_lfsr, n_P, n_H);
            m_lfsr = (m_lfsr >> 1) ^ (((m_lfsr & 1) != 0) ? 'hB400 : 0);
        end
        if (m_xfer) begin
            s_per  = (cfg_period < 2)   ? 2   : longint'(cfg_period);
            s_duty = (cfg_duty > 100)   ? 100 : longint'(cfg_duty);
            s_jit  = (cfg_jitter > 50)  ? 50  : longint'(cfg_jitter);
            e_err  = (cfg_period < 2) || (cfg_duty > 100) || (cfg_jitter > 50);
            m_full = 1;
        end
        case (m_mode)
            MI:  if (enable) m_mode = MP1;
            MP1: m_mode = MP2;
            MP2: start_period();
            default: begin
                if (m_pos + 1 == m_P) begin
                    if (enable) start_period();
                    else m_mode = MI;
                end else begin
                    m_pos++;
                end
            end
        endcase
        e_clk   = (m_mode == MR) && (m_pos < m_H);
        e_ready = !m_full;
        e_busy  = (m_mode != MI);
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step();
        #1;
        if (rst_n) begin
            chk("out_clk", out_clk, e_clk);
            chk("out_rise", out_rise, e_rise);
            chk("cur_period", cur_period, e_cur);
            chk("cfg_ready", cfg_ready, e_ready);
            chk("cfg_err", cfg_err, e_err);
            chk("busy", busy, e_busy);
        end
    endtask

    task automatic send_cfg(input int p, input int d, input int j);
        int g = 0;
        cfg_valid = 1; cfg_period = 16'(p); cfg_duty = 7'(d); cfg_jitter = 6'(j);
        do begin tick(); g++; end while (!m_xfer && g < 500);
        if (!m_xfer) chk("cfg_timeout", 0, 1);
        cfg_valid = 0;
    endtask

    task automatic wait_rises(input int n);
        int got = 0, g = 0;
        while (got < n && g < 5000) begin
            tick(); g++;
            if (e_rise) got++;
        end
        if (got < n) chk("rise_timeout", got, n);
    endtask

    // Measures the period beginning at the current or next observed rise.
    task automatic measure(output longint p, output longint h);
        int g = 0;
        p = 0; h = 0;
        while (!out_rise && g < 5000) begin tick(); g++; end
        do begin
            if (out_clk) h++;
            p++; tick(); g++;
        end while (!out_rise && g < 10000);
        if (g >= 10000) chk("measure_timeout", g, 0);
    endtask

    initial begin
        longint p, h;
        int n;
        bit seen95, seen105;
        model_reset();
        #12;
        chk("rst_out_clk", out_clk, 0);
        chk("rst_out_rise", out_rise, 0);
        chk("rst_cfg_ready", cfg_ready, 1);
        chk("rst_cfg_err", cfg_err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cur_period", cur_period, 0);
        rst_n = 1;

        // 1: basic 10-cycle 50% clock, enable latency
        send_cfg(10, 50, 0);
        enable = 1;
        n = 0;
        do begin tick(); n++; end while (!out_rise && n < 20);
        chk("t1_latency", n, 3);
        chk("t1_cur", cur_period, 10);
        measure(p, h);
        chk("t1_P", p, 10);
        chk("t1_H", h, 5);

        // 2: duty variations
        send_cfg(10, 30, 0); wait_rises(2); measure(p, h);
        chk("t2_P30", p, 10); chk("t2_H30", h, 3);
        send_cfg(10, 0, 0); wait_rises(2); measure(p, h);
        chk("t2_H0", h, 1);
        send_cfg(10, 100, 0); wait_rises(2); measure(p, h);
        chk("t2_H100", h, 9);

        // 3: every field clamped
        send_cfg(1, 120, 60);
        chk("t3_err", cfg_err, 1);
        tick();
        chk("t3_err_pulse", cfg_err, 0);
        wait_rises(2); measure(p, h);
        chk("t3_P_range", (p >= 2 && p <= 3), 1);
        chk("t3_L", p - h, 1);

        // 4: jitter distribution
        send_cfg(100, 50, 5); wait_rises(3);
        seen95 = 0; seen105 = 0;
        repeat (500) begin
            wait_rises(1);
            chk("t4_range", (cur_period >= 95 && cur_period <= 105), 1);
            if (cur_period == 95) seen95 = 1;
            if (cur_period == 105) seen105 = 1;
        end
        chk("t4_seen95", seen95, 1);
        chk("t4_seen105", seen105, 1);

        // 5: mid-period config change and held-off second request
        send_cfg(10, 50, 0); wait_rises(3);
        wait_rises(1); repeat (4) tick();
        cfg_valid = 1; cfg_period = 16'd20; cfg_duty = 7'd50; cfg_jitter = 6'd0;
        tick();
        chk("t5_hold", cfg_ready, 0);
        measure(p, h); chk("t5_P_next", p, 10);
        measure(p, h); chk("t5_P_after", p, 20);
        cfg_valid = 0;
        wait_rises(2);

        // 6: disable mid-HIGH, then async reset mid-HIGH with a pending shadow
        wait_rises(1); tick();
        enable = 0;
        repeat (30) tick();
        chk("t6_idle", busy, 0);
        enable = 1;
        wait_rises(2);
        cfg_valid = 1; cfg_period = 16'd15;
        tick();
        cfg_valid = 0;
        chk("t6_pre_clk", out_clk, 1);
        chk("t6_pre_ready", cfg_ready, 0);
        #2 rst_n = 0;
        #1;
        chk("t6_rst_clk", out_clk, 0);
        chk("t6_rst_ready", cfg_ready, 1);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_cur", cur_period, 0);
        model_reset();
        enable = 0;
        tick(); tick();
        rst_n = 1;

        // random traffic
        repeat (3000) begin
            if ($urandom_range(0, 49) == 0) enable = ~enable;
            cfg_valid  = ($urandom_range(0, 3) == 0);
            cfg_period = 16'($urandom_range(0, 40));
            cfg_duty   = 7'($urandom_range(0, 127));
            cfg_jitter = 6'($urandom_range(0, 63));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
